// File: rtl/tri_read_arbiter_if.sv
// Signal bundle between tri_read_arbiter, its requesters and the shared tri_reader.
// master: arbiter side; slave: requesters plus tri_reader side.
interface tri_read_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int NDWORDS = 9
);
  localparam int BLOCKSZ = 32 * NDWORDS;

  logic [NREQ-1:0]      req_read;
  logic [32*NREQ-1:0]   req_index;
  logic [NREQ-1:0]      req_done;
  logic [BLOCKSZ-1:0]   req_data;
  logic                 tr_read;
  logic [31:0]          tr_index;
  logic [BLOCKSZ-1:0]   tr_data;
  logic                 tr_done;
  logic [31:0]          stat_txns;
  logic [31:0]          stat_busy;

  modport master (
    input  req_read, req_index, tr_data, tr_done,
    output req_done, req_data, tr_read, tr_index, stat_txns, stat_busy
  );

  modport slave (
    output req_read, req_index, tr_data, tr_done,
    input  req_done, req_data, tr_read, tr_index, stat_txns, stat_busy
  );
endinterface

// File: rtl/tri_read_arbiter.sv
// Round-robin arbiter sharing one tri_reader among NREQ requesters.
// Optional statistics counters are built when TRI_ARB_STATS_EN is defined.
module tri_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int NDWORDS = 9
) (
  input  logic               clk,
  input  logic               reset,
  tri_read_arbiter_if.master bus
);
  localparam int BLOCKSZ = 32 * NDWORDS;
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      win_s;
  logic               win_found_s;
  logic [31:0]        idx_q, idx_d;
  logic               tr_read_q, tr_read_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [BLOCKSZ-1:0] data_q, data_d;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] sel);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (sel == GW'(i));
    end
    return v;
  endfunction

  // Round-robin search: the first requesting slot after last_q wins.
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found_s && bus.req_read[(int'(last_q) + k) % NREQ]) begin
        win_found_s = 1'b1;
        win_s       = GW'((int'(last_q) + k) % NREQ);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output values for the IDLE/ISSUE/RESP sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = '0;
    tr_read_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_d   = win_s;
          last_d    = win_s;
          idx_d     = bus.req_index[32*int'(win_s) +: 32];
          tr_read_d = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        if (bus.tr_done) begin
          data_d  = bus.tr_data;
          done_d  = onehot(grant_q);
          state_d = RESP;
        end else begin
          tr_read_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset also kills any pending completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NREQ - 1);
      idx_q     <= 32'd0;
      tr_read_q <= 1'b0;
      done_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      tr_read_q <= tr_read_d;
      done_q    <= done_d;
      data_q    <= data_d;
    end
  end

  assign bus.tr_read  = tr_read_q;
  assign bus.tr_index = idx_q;
  assign bus.req_done = done_q;
  assign bus.req_data = data_q;

`ifdef TRI_ARB_STATS_EN
  logic [31:0] txns_q;
  logic [31:0] busy_q;

  // Completed-transaction and ISSUE-cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txns_q <= 32'd0;
      busy_q <= 32'd0;
    end else begin
      if (state_q == RESP) begin
        txns_q <= txns_q + 32'd1;
      end
      if (state_q == ISSUE) begin
        busy_q <= busy_q + 32'd1;
      end
    end
  end

  assign bus.stat_txns = txns_q;
  assign bus.stat_busy = busy_q;
`else
  assign bus.stat_txns = 32'd0;
  assign bus.stat_busy = 32'd0;
`endif
endmodule

// File: doc/tri_read_arbiter.md
# tri_read_arbiter

Round-robin arbiter that shares one `tri_reader` (cached, AVMM-backed triangle fetch unit) among `NREQ` ray-intersection requesters. It latches the winning requester's triangle index and holds the reader's `read`/`index` stable until `done`. It then registers the 288-bit triangle block and returns it to that requester with a one-cycle completion pulse. It sits between the ray units and the single `tri_reader` instance in the system.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 1..16.
- `NDWORDS`, 9: 32-bit words per triangle; must match `tri_reader`.
- `BLOCKSZ`, 32*NDWORDS: triangle block width (localparam).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_read`  in  NREQ  per-requester read request; held high until the matching `req_done`.
- `req_index`  in  32*NREQ  per-requester triangle index; slice i is bits [32i+31:32i].
- `req_done`  out  NREQ  one-hot, one-cycle completion pulse.
- `req_data`  out  BLOCKSZ  registered triangle block, shared by all requesters; valid while any `req_done` bit is high.
- `tr_read`  out  1  to `tri_reader.read`.
- `tr_index`  out  32  to `tri_reader.index`.
- `tr_data`  in  BLOCKSZ  from `tri_reader.data`.
- `tr_done`  in  1  from `tri_reader.done`.
- `stat_txns`  out  32  count of completed transactions (see Configuration).
- `stat_busy`  out  32  count of cycles spent in ISSUE (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: when any `req_read` bit is high, select a winner by round-robin starting at `last_grant+1` (mod NREQ).
  - Latch `req_index` of the winner into `idx_q` and the winner number into `grant_q`.
  - Set `last_grant <= winner` and move to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE: `tr_read=1`, `tr_index=idx_q`.
  - When `tr_done=1`, capture `tr_data` into `req_data` and move to RESP.
  - Otherwise stay in ISSUE with no timeout.
- RESP: `req_done[grant_q]=1`, `tr_read=0`, then move to IDLE unconditionally.
- Grants are not cancellable. If the granted requester drops `req_read` or changes its index during ISSUE, the arbiter ignores it: the transaction completes with the latched index and `req_done` still pulses.
- Requesters must drop `req_read` on the cycle after seeing `req_done`. RESP→IDLE guarantees the arbiter never re-grants a requester from a stale request.
- Round-robin rule: after requester k is served, requester k has the lowest priority. No requester waits more than NREQ-1 transactions.
- NREQ=1 degenerates to a pass-through sequencer that always grants requester 0.

## Timing
- Reset values:
  - `req_done=0`, `req_data=0`, `tr_read=0`, `tr_index=0`.
  - `stat_txns=0`, `stat_busy=0`.
  - `last_grant=NREQ-1`, so requester 0 wins the first arbitration.
- Asserting `reset` mid-transaction immediately forces IDLE, drops `tr_read`, and suppresses the pending `req_done`. The system must reset `tri_reader` in the same window.
- Latency, request seen in IDLE at cycle 0:
  - `tr_read` is high from cycle 1.
  - With a cache hit (`tr_done` at cycle 2), `req_done` and `req_data` are valid at cycle 3.
  - With a miss, `req_done` is valid 1 cycle after `tr_done`.
- Back-to-back transactions: a new grant happens in the IDLE cycle after RESP. Minimum spacing between successive `tr_read` rising edges is 3 cycles.
- `tr_read` and `tr_index` are registered outputs. They are stable for the whole of ISSUE and low/unchanged outside it.
- When several requests rise in the same cycle, only the round-robin winner is granted. The others stay pending with no loss.

## Configuration
- `TRI_ARB_STATS_EN` defined:
  - `stat_txns` increments on every RESP cycle.
  - `stat_busy` increments on every ISSUE cycle.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Not defined: both ports are tied to constant 0 and no counter logic is built.

## Test plan
- Single requester 0 at index 5, `tr_done` asserted the cycle after `tr_read` rises, `tr_data`=0xABCD… → `tr_index`=5 during ISSUE; `req_done`=4'b0001 at cycle 3; `req_data` equals the driven block.
- All four requesters high from reset, each miss takes 10 cycles → grant order 0,1,2,3,0; exactly one `req_done` bit per transaction; `tr_read` gap is 2 cycles between transactions.
- Requester 2 changes `req_index` from 7 to 9 and drops `req_read` during ISSUE → `tr_index` stays 7 and `req_done[2]` still pulses once.
- `reset` asserted while in ISSUE → `tr_read` and `req_done` go to 0 without waiting for a clock; no `req_done` after release; next grant goes to requester 0.
- With `TRI_ARB_STATS_EN`, three transactions with ISSUE lengths 2, 5 and 10 → `stat_txns`=3, `stat_busy`=17; without the macro both read 0.
